result_writer: RTL and testbench

//  AVMM write master that stores one record of NDWORDS 32-bit words to SDRAM as 16-bit beats.

---
 rtl/result_writer_pkg.sv | 32 +++
 rtl/result_writer_if.sv | 27 ++
 rtl/result_writer_halfword_serializer.sv | 49 ++++
 rtl/result_writer.sv | 151 +++++++++++++++
 tb/tb_result_writer.sv | 315 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/result_writer_pkg.sv
// Shared definitions for the result writer: fixed-point type, AVMM halfword
// bus widths, result record layout and the record address helper.
package result_writer_pkg;

    // AVMM halfword data path and byte-enable widths
    localparam int AVMM_HW_W = 16;
    localparam int AVMM_BE_W = 2;

    // Q16.16 fixed-point type carried in the t field of a result record
    typedef logic signed [31:0] fip;
    localparam fip FIP_ONE = 32'sh0001_0000;
    localparam fip FIP_MIN = 32'sh8000_0000;
    localparam fip FIP_MAX = 32'sh7FFF_FFFF;

    // Word positions inside a result record
    localparam int RES_HIT = 0;
    localparam int RES_T   = 1;
    localparam int RES_IDX = 2;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_WRITE = 1'b1
    } rw_state_e;

    // First halfword address of record 'index'; 32-bit wrap-around, no saturation
    function automatic logic [31:0] record_beat_addr(input logic [31:0] baseaddr,
                                                     input logic [31:0] index,
                                                     input int          nbeats);
        return baseaddr + index * 32'(nbeats);
    endfunction

endpackage

// File: rtl/result_writer_if.sv
// AVMM write-master bus between result_writer and the SDRAM controller.
interface result_writer_if;
    import result_writer_pkg::*;

    logic                 avm_m0_write;
    logic [31:0]          avm_m0_address;
    logic [AVMM_HW_W-1:0] avm_m0_writedata;
    logic [AVMM_BE_W-1:0] avm_m0_byteenable;
    logic                 avm_m0_waitrequest;

    modport master (
        output avm_m0_write,
        output avm_m0_address,
        output avm_m0_writedata,
        output avm_m0_byteenable,
        input  avm_m0_waitrequest
    );

    modport slave (
        input  avm_m0_write,
        input  avm_m0_address,
        input  avm_m0_writedata,
        input  avm_m0_byteenable,
        output avm_m0_waitrequest
    );

endinterface

// File: rtl/result_writer_halfword_serializer.sv
// Holds the latched record and walks it out one halfword per completed beat.
// The beat counter only moves on a cycle with write=1 and waitrequest=0, so the
// presented halfword stays put while the slave stalls.
module result_writer_halfword_serializer
    import result_writer_pkg::*;
#(
    parameter  int NDWORDS = 3,
    localparam int NBEATS  = 2 * NDWORDS,
    localparam int BEAT_W  = $clog2(NBEATS)
) (
    input  logic                    i_clk,
    input  logic                    i_rstn,
    input  logic                    load,
    input  logic [32*NDWORDS-1:0]   load_data,
    input  logic                    write,
    input  logic                    waitrequest,
    output logic [BEAT_W-1:0]       beat,
    output logic                    last_done,
    output logic [AVMM_HW_W-1:0]    writedata
);

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NBEATS - 1);

    logic [NBEATS-1:0][AVMM_HW_W-1:0] data_q;
    logic                             beat_done;

    assign beat_done = write && !waitrequest;
    assign last_done = beat_done && (beat == LAST_BEAT);
    assign writedata = write ? data_q[beat] : '0;

    // Capture the record halfwords when a new record is started
    always_ff @(posedge i_clk) begin
        if (load) begin
            data_q <= load_data;
        end
    end

    // Beat counter: restart on load, advance on each completed non-final beat
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            beat <= '0;
        end else if (load) begin
            beat <= '0;
        end else if (beat_done && (beat != LAST_BEAT)) begin
            beat <= beat + 1'b1;
        end
    end

endmodule

// File: rtl/result_writer.sv
// AVMM write master storing one NDWORDS-word result record as 2*NDWORDS
// halfword beats at baseaddr + index*2*NDWORDS.
// Optional feature: RESULT_WRITER_SKID_EN adds a one-entry request buffer so a
// request arriving during a write is issued back-to-back with the current one.
module result_writer
    import result_writer_pkg::*;
#(
    parameter int NDWORDS = 3
) (
    input  logic                    i_clk,
    input  logic                    i_rstn,
    input  logic                    i_valid,
    output logic                    o_ready,
    input  logic [31:0]             i_baseaddr,
    input  logic [31:0]             i_index,
    input  logic [32*NDWORDS-1:0]   i_data,
    output logic                    o_done,
    result_writer_if.master         avm
);

    localparam int NBEATS = 2 * NDWORDS;
    localparam int BEAT_W = $clog2(NBEATS);

    rw_state_e               state_q;
    rw_state_e               state_d;
    logic                    write;
    logic                    accept;
    logic                    load;
    logic [31:0]             req_base;
    logic [31:0]             load_base;
    logic [32*NDWORDS-1:0]   load_data;
    logic [31:0]             base_q;
    logic                    done_q;
    logic [BEAT_W-1:0]       beat;
    logic                    last_done;
    logic [AVMM_HW_W-1:0]    writedata;

    assign write    = (state_q == ST_WRITE);
    assign req_base = record_beat_addr(i_baseaddr, i_index, NBEATS);
    assign accept   = i_valid && o_ready;

`ifdef RESULT_WRITER_SKID_EN
    logic                    buf_full_q;
    logic [31:0]             buf_base_q;
    logic [32*NDWORDS-1:0]   buf_data_q;
    logic                    buf_fill;
    logic                    buf_take;

    assign o_ready = !buf_full_q;
    // A request that cannot start directly (writing, not at the last beat) parks in the buffer
    assign buf_fill = accept && write && !last_done;

    // Buffer occupancy flag
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            buf_full_q <= 1'b0;
        end else if (buf_fill) begin
            buf_full_q <= 1'b1;
        end else if (buf_take) begin
            buf_full_q <= 1'b0;
        end
    end

    // Buffered request payload, base address already resolved
    always_ff @(posedge i_clk) begin
        if (buf_fill) begin
            buf_base_q <= req_base;
            buf_data_q <= i_data;
        end
    end
`else
    assign o_ready = (state_q == ST_IDLE);
`endif

    // Next-state and record-load selection
    always_comb begin
        state_d   = state_q;
        load      = 1'b0;
        load_base = req_base;
        load_data = i_data;
`ifdef RESULT_WRITER_SKID_EN
        buf_take  = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    load    = 1'b1;
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (last_done) begin
`ifdef RESULT_WRITER_SKID_EN
                    if (buf_full_q) begin
                        load      = 1'b1;
                        load_base = buf_base_q;
                        load_data = buf_data_q;
                        buf_take  = 1'b1;
                    end else if (accept) begin
                        load      = 1'b1;
                    end else begin
                        state_d   = ST_IDLE;
                    end
`else
                    state_d = ST_IDLE;
`endif
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State register and registered completion pulse
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= last_done;
        end
    end

    // Record base halfword address, captured with the record
    always_ff @(posedge i_clk) begin
        if (load) begin
            base_q <= load_base;
        end
    end

    result_writer_halfword_serializer #(
        .NDWORDS (NDWORDS)
    ) u_ser (
        .i_clk       (i_clk),
        .i_rstn      (i_rstn),
        .load        (load),
        .load_data   (load_data),
        .write       (write),
        .waitrequest (avm.avm_m0_waitrequest),
        .beat        (beat),
        .last_done   (last_done),
        .writedata   (writedata)
    );

    assign o_done                = done_q;
    assign avm.avm_m0_write      = write;
    assign avm.avm_m0_address    = write ? (base_q + 32'(beat)) : '0;
    assign avm.avm_m0_writedata  = writedata;
    assign avm.avm_m0_byteenable = write ? 2'b11 : 2'b00;

endmodule

// File: tb/tb_result_writer.sv
// Directed bench for result_writer: a queue of expected halfword beats built from
// base + index*6 + b and record slicing, checked on every completed bus beat.
module tb_result_writer;
    import result_writer_pkg::*;

    localparam int NDW = 3;
    localparam int NB  = 2 * NDW;

    logic            clk;
    logic            i_rstn;
    logic            i_valid;
    logic            o_ready;
    logic [31:0]     i_baseaddr;
    logic [31:0]     i_index;
    logic [32*NDW-1:0] i_data;
    logic            o_done;

    result_writer_if avm_if();

    result_writer #(.NDWORDS(NDW)) dut (
        .i_clk      (clk),
        .i_rstn     (i_rstn),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .i_baseaddr (i_baseaddr),
        .i_index    (i_index),
        .i_data     (i_data),
        .o_done     (o_done),
        .avm        (avm_if.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [15:0] data;
        bit          last;
    } beat_t;

    beat_t       exp_q[$];
    logic [31:0] obs_addr[$];
    logic [15:0] obs_data[$];
    int          checks = 0;
    int          errors = 0;
    int          beats_done = 0;
    int          done_cnt = 0;
    int          run_len = 0;
    int          max_run = 0;
    bit          mon_en = 1'b0;
    bit          done_pending = 1'b0;
    bit          prev_stall = 1'b0;
    logic [31:0] prev_addr;
    logic [15:0] prev_data;

    logic [31:0] t2_addr[NB] = '{32'h10C, 32'h10D, 32'h10E, 32'h10F, 32'h110, 32'h111};
    logic [15:0] t2_data[NB] = '{16'h0001, 16'h0000, 16'h8000, 16'h0001, 16'h0000, 16'hFFFF};
    logic [31:0] t4_addr[NB] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0, 32'h1, 32'h2, 32'h3};

    function automatic logic [32*NDW-1:0] rec(input logic [31:0] hit, input logic [31:0] t,
                                              input logic [31:0] idx);
        logic [32*NDW-1:0] r;
        r = '0;
        r[32*RES_HIT +: 32] = hit;
        r[32*RES_T   +: 32] = t;
        r[32*RES_IDX +: 32] = idx;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Model: a record is six beats at consecutive halfword addresses, low half first
    task automatic push_record(input logic [31:0] base, input logic [31:0] idx,
                               input logic [32*NDW-1:0] data);
        beat_t b;
        for (int k = 0; k < NB; k++) begin
            b.addr = base + idx * 32'd6 + 32'(k);
            b.data = data[16*k +: 16];
            b.last = (k == NB - 1);
            exp_q.push_back(b);
        end
    endtask

    task automatic send(input logic [31:0] base, input logic [31:0] idx,
                        input logic [32*NDW-1:0] data, input string name);
        int n;
        bit acc;
        i_baseaddr = base;
        i_index    = idx;
        i_data     = data;
        i_valid    = 1'b1;
        n   = 0;
        acc = 1'b0;
        while (!acc && n < 100) begin
            @(negedge clk);
            acc = (o_ready === 1'b1);
            @(posedge clk);
            #1;
            n++;
        end
        i_valid = 1'b0;
        chk({name, "_accepted"}, {31'd0, acc}, 32'd1);
        if (acc) push_record(base, idx, data);
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (o_done !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_done_seen"}, {31'd0, (n < 200)}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_beats(input int target, input string name);
        int n;
        n = 0;
        while (beats_done != target && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({name, "_beat_reached"}, {31'd0, (n < 50)}, 32'd1);
    endtask

    // Per-cycle comparison of the bus against the expected-beat queue
    always @(negedge clk) begin
        if (mon_en) begin
            chk("done_pulse", {31'd0, o_done}, {31'd0, done_pending});
            if (o_done === 1'b1) done_cnt++;
            done_pending = 1'b0;
            if (prev_stall) begin
                chk("stall_write_held", {31'd0, avm_if.avm_m0_write}, 32'd1);
                chk("stall_addr_held", avm_if.avm_m0_address, prev_addr);
                chk("stall_data_held", {16'd0, avm_if.avm_m0_writedata}, {16'd0, prev_data});
            end
            if (avm_if.avm_m0_write === 1'b1) run_len++;
            else run_len = 0;
            if (run_len > max_run) max_run = run_len;
            if (i_rstn && avm_if.avm_m0_write === 1'b1 && !avm_if.avm_m0_waitrequest) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got write at %h expected no write",
                             avm_if.avm_m0_address);
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    chk("beat_addr", avm_if.avm_m0_address, e.addr);
                    chk("beat_data", {16'd0, avm_if.avm_m0_writedata}, {16'd0, e.data});
                    chk("beat_be", {30'd0, avm_if.avm_m0_byteenable}, 32'd3);
                    obs_addr.push_back(avm_if.avm_m0_address);
                    obs_data.push_back(avm_if.avm_m0_writedata);
                    beats_done++;
                    if (e.last) done_pending = 1'b1;
                end
            end
            prev_stall = i_rstn && (avm_if.avm_m0_write === 1'b1) && avm_if.avm_m0_waitrequest;
            prev_addr  = avm_if.avm_m0_address;
            prev_data  = avm_if.avm_m0_writedata;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int start;
        int d0;
        i_rstn     = 1'b0;
        i_valid    = 1'b1;
        i_baseaddr = 32'h40;
        i_index    = 32'h1;
        i_data     = rec(32'h1, 32'h2, 32'h3);
        avm_if.avm_m0_waitrequest = 1'b0;

        // 1: reset held 3 cycles with i_valid high; reset wins
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_ready", {31'd0, o_ready}, 32'd1);
        chk("rst_write", {31'd0, avm_if.avm_m0_write}, 32'd0);
        chk("rst_done", {31'd0, o_done}, 32'd0);
        chk("rst_addr", avm_if.avm_m0_address, 32'd0);
        chk("rst_wdata", {16'd0, avm_if.avm_m0_writedata}, 32'd0);
        chk("rst_be", {30'd0, avm_if.avm_m0_byteenable}, 32'd0);
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        i_rstn  = 1'b1;
        mon_en  = 1'b1;
        @(posedge clk);
        #1;

        // 2: basic record, literal addresses and data
        obs_addr.delete();
        obs_data.delete();
        send(32'h100, 32'd2, rec(32'h1, FIP_ONE + 32'sh8000, 32'hFFFF_0000), "t2");
        wait_done("t2");
        chk("t2_nbeats", obs_addr.size(), NB);
        for (int k = 0; k < NB && k < obs_addr.size(); k++) begin
            chk("t2_lit_addr", obs_addr[k], t2_addr[k]);
            chk("t2_lit_data", {16'd0, obs_data[k]}, {16'd0, t2_data[k]});
        end

        // 3: waitrequest held 4 cycles on beat 3
        start = beats_done;
        send(32'h2000, 32'd1, rec(32'hDEAD_BEEF, 32'h1234_5678, 32'hCAFE_BABE), "t3");
        wait_beats(start + 3, "t3");
        avm_if.avm_m0_waitrequest = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("t3_stall_addr", avm_if.avm_m0_address, 32'h2009);
            chk("t3_stall_data", {16'd0, avm_if.avm_m0_writedata}, 32'h1234);
            @(posedge clk);
            #1;
        end
        avm_if.avm_m0_waitrequest = 1'b0;
        wait_done("t3");
        chk("t3_nbeats", beats_done - start, NB);

        // 4: address wrap-around
        obs_addr.delete();
        obs_data.delete();
        send(32'hFFFF_FFFE, 32'd0, rec(32'h0, FIP_MAX, FIP_MIN), "t4");
        wait_done("t4");
        chk("t4_nbeats", obs_addr.size(), NB);
        for (int k = 0; k < NB && k < obs_addr.size(); k++) begin
            chk("t4_lit_addr", obs_addr[k], t4_addr[k]);
        end

        // 5: reset after beat 2, record abandoned, then a full record
        start = beats_done;
        d0    = done_cnt;
        send(32'h300, 32'd4, rec(32'h1111_2222, 32'h3333_4444, 32'h5555_6666), "t5a");
        wait_beats(start + 3, "t5");
        i_rstn = 1'b0;
        exp_q.delete();
        @(posedge clk);
        #1;
        i_rstn = 1'b1;
        @(negedge clk);
        chk("t5_write_dropped", {31'd0, avm_if.avm_m0_write}, 32'd0);
        chk("t5_ready", {31'd0, o_ready}, 32'd1);
        repeat (4) @(posedge clk);
        #1;
        chk("t5_no_done", done_cnt - d0, 0);
        start = beats_done;
        send(32'h300, 32'd4, rec(32'h1111_2222, 32'h3333_4444, 32'h5555_6666), "t5b");
        wait_done("t5b");
        chk("t5_full_record", beats_done - start, NB);

`ifdef RESULT_WRITER_SKID_EN
        // 6: back-to-back requests through the buffer
        d0      = done_cnt;
        max_run = 0;
        send(32'h500, 32'd0, rec(32'hA, 32'hB, 32'hC), "t6a");
        send(32'h500, 32'd1, rec(32'hD, 32'hE, 32'hF), "t6b");
        @(negedge clk);
        chk("t6_ready_full", {31'd0, o_ready}, 32'd0);
        @(posedge clk);
        #1;
        send(32'h500, 32'd2, rec(32'h10, 32'h11, 32'h12), "t6c");
        begin
            int n;
            n = 0;
            while (done_cnt != d0 + 3 && n < 200) begin
                @(posedge clk);
                #1;
                n++;
            end
        end
        chk("t6_done_pulses", done_cnt - d0, 3);
        chk("t6_no_gap", {31'd0, (max_run >= 12)}, 32'd1);
`else
        // Base build: requests during a write are ignored
        start = beats_done;
        send(32'h700, 32'd0, rec(32'h21, 32'h22, 32'h23), "tb");
        i_baseaddr = 32'h900;
        i_data     = rec(32'h31, 32'h32, 32'h33);
        i_valid    = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("tb_not_ready", {31'd0, o_ready}, 32'd0);
            @(posedge clk);
            #1;
        end
        i_valid = 1'b0;
        wait_done("tb");
        repeat (8) @(posedge clk);
        #1;
        chk("tb_only_one_record", beats_done - start, NB);
`endif

        repeat (5) @(posedge clk);
        #1;
        chk("all_beats_written", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
